cps_input_conditioner: RTL
==========================

Name: cps_input_conditioner

Overview:
Front-end stage that feeds car_parking_system. It synchronizes and debounces the raw entrance sensor, exit sensor and keypad strobe. It emits clean sensor levels and one-cycle edge pulses. It also captures the 4-bit keypad code into a held passwordEntered value inside a timed entry window.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from its debounced level before the level flips (min 1)
PW_TIMEOUT_CYCLES, 1000, cycles allowed in ARMED without a key press before timeout (min 2)

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  asynchronous, active-low reset (low = reset)
sensorEntranceRaw  input  1  raw entrance sensor, asynchronous, may bounce
sensorExitRaw  input  1  raw exit sensor, asynchronous, may bounce
keyValidRaw  input  1  raw keypad strobe, high while key held
keyCode  input  4  keypad code, stable while keyValidRaw high
sensorEntrance  output  1  debounced entrance level, to car_parking_system
sensorExit  output  1  debounced exit level, to car_parking_system
entrancePulse  output  1  one-cycle pulse on debounced entrance 0->1
exitPulse  output  1  one-cycle pulse on debounced exit 0->1
passwordEntered  output  4  captured code, to car_parking_system
passwordValid  output  1  one-cycle pulse when a new code is captured
passwordTimeout  output  1  one-cycle pulse when the entry window expires
pwState  output  2  current password FSM state, for debug

Behaviour:
- Reset (Rst low, asynchronous): all outputs 0, all synchronizer flops 0, all debounce counters 0, timer 0, FSM to IDLE.
- Per input: 2-flop synchronizer, then debouncer.
  - Counter increments while the synchronized value differs from the debounced level. It clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the level flips and the counter clears.
  - Latency: a clean raw step reaches the debounced output DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the output.
- Pulses (entrancePulse, exitPulse, internal keyPulse) are registered and asserted in the same cycle the debounced level rises. No pulse on a fall.
- Entrance and exit paths are fully independent. Simultaneous pulses are both asserted.
- Password FSM states: IDLE=0, ARMED=1, HOLD=2.
  - IDLE:
    - On entrancePulse: go ARMED, timer cleared to 0.
    - keyPulse is ignored.
    - passwordEntered = 0.
  - ARMED:
    - Timer increments each cycle.
    - On keyPulse: passwordEntered <= keyCode (sampled at the synchronized edge), passwordValid pulses one cycle, go HOLD.
    - Else if timer == PW_TIMEOUT_CYCLES-1: passwordTimeout pulses one cycle, passwordEntered <= 0, go IDLE.
    - A key press in the same cycle as the timeout wins: capture, no timeout pulse.
    - A further entrancePulse in ARMED is ignored and does not restart the timer.
  - HOLD:
    - passwordEntered is held stable.
    - On keyPulse (retry): recapture keyCode, pulse passwordValid again, stay HOLD.
    - On debounced sensorEntrance falling (car left the entrance sensor): passwordEntered <= 0, go IDLE.
    - If a key and the fall occur in the same cycle, the fall wins.
- passwordValid and passwordTimeout are never high together. Each pulse lasts exactly one cycle.
- Timer width is clog2(PW_TIMEOUT_CYCLES). It saturates and never wraps; it is cleared on every entry into ARMED.
- Reset asserted mid-operation (any state, mid-debounce) returns to the reset values immediately. No pulse is emitted on reset release.

Decomposition:
- Package cps_pkg holds:
  - the pw_state_t enum (IDLE, ARMED, HOLD)
  - the 4-bit password width constant
  - default DEBOUNCE_CYCLES and PW_TIMEOUT_CYCLES localparams
- Sub-module cps_debouncer (parameter DEBOUNCE_CYCLES; ports Clk, Rst, rawIn, level, risePulse) contains the synchronizer, counter and edge detect. It is instantiated three times: entrance, exit, keypad strobe.
- The top level contains the FSM, timer and capture register.

Test Plan (DEBOUNCE_CYCLES=4, PW_TIMEOUT_CYCLES=20):
- Debounce: raw entrance 0->1 held -> sensorEntrance and entrancePulse rise 6 edges later. A 3-cycle raw glitch -> no output change.
- Normal entry: entrance held high, key 4'hA pressed 5 cycles after entrancePulse -> passwordEntered=4'hA, passwordValid one cycle, FSM HOLD. Entrance released -> passwordEntered=0, IDLE.
- Timeout: entrancePulse, no key -> passwordTimeout pulses exactly 20 cycles after entering ARMED. FSM IDLE, passwordEntered=0.
- Retry and ignore: key 4'h3 then key 4'h7 in HOLD -> two passwordValid pulses, final value 4'h7. Key 4'h5 while IDLE -> no pulse, value stays 0.
- Simultaneous: entrance and exit raw rise on the same edge -> entrancePulse and exitPulse high in the same cycle.
- Reset mid-operation: Rst low while in HOLD with 4'h9 -> all outputs 0 asynchronously. After Rst high, no pulses until new debounced edges.

Source files
------------

// File: rtl/cps_pkg.sv
// Shared types and defaults for the parking-system input conditioner.
package cps_pkg;

  localparam int unsigned PW_WIDTH                  = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 16;
  localparam int unsigned DEFAULT_PW_TIMEOUT_CYCLES = 1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } pw_state_t;

endpackage

// File: rtl/cps_debouncer.sv
// Two-flop synchronizer followed by a counting debouncer with a registered rising-edge pulse.
module cps_debouncer
  import cps_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic rawIn,
  output logic level,
  output logic risePulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncQ1;
  logic             syncQ2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             flip;

  assign differ = syncQ2 ^ level;
  assign flip   = differ && (cnt == CNT_LAST);

  // Level flips only after the synchronized input has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      syncQ1    <= 1'b0;
      syncQ2    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      risePulse <= 1'b0;
    end else begin
      syncQ1    <= rawIn;
      syncQ2    <= syncQ1;
      risePulse <= flip & syncQ2;
      if (flip) begin
        level <= syncQ2;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cps_input_conditioner.sv
// Debounces the entrance/exit sensors and keypad strobe, and captures the keypad code
// inside a timed entry window opened by a car arriving at the entrance.
module cps_input_conditioner
  import cps_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned PW_TIMEOUT_CYCLES = DEFAULT_PW_TIMEOUT_CYCLES
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                sensorEntranceRaw,
  input  logic                sensorExitRaw,
  input  logic                keyValidRaw,
  input  logic [PW_WIDTH-1:0] keyCode,
  output logic                sensorEntrance,
  output logic                sensorExit,
  output logic                entrancePulse,
  output logic                exitPulse,
  output logic [PW_WIDTH-1:0] passwordEntered,
  output logic                passwordValid,
  output logic                passwordTimeout,
  output logic [1:0]          pwState
);

  localparam int unsigned TIMER_W = $clog2(PW_TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PW_TIMEOUT_CYCLES - 1);

  pw_state_t           state;
  pw_state_t           stateNext;
  logic [TIMER_W-1:0]  timer;
  logic [TIMER_W-1:0]  timerNext;
  logic [PW_WIDTH-1:0] pwNext;
  logic                validNext;
  logic                timeoutNext;
  logic                keyPulse;
  logic                unusedKeyLevel;
  logic                entPrev;
  logic                entranceFall;

  cps_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uEntrance (
    .Clk(Clk), .Rst(Rst), .rawIn(sensorEntranceRaw),
    .level(sensorEntrance), .risePulse(entrancePulse)
  );

  cps_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uExit (
    .Clk(Clk), .Rst(Rst), .rawIn(sensorExitRaw),
    .level(sensorExit), .risePulse(exitPulse)
  );

  cps_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKey (
    .Clk(Clk), .Rst(Rst), .rawIn(keyValidRaw),
    .level(unusedKeyLevel), .risePulse(keyPulse)
  );

  assign entranceFall = entPrev & ~sensorEntrance;
  assign pwState      = state;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state           <= IDLE;
      timer           <= '0;
      passwordEntered <= '0;
      passwordValid   <= 1'b0;
      passwordTimeout <= 1'b0;
      entPrev         <= 1'b0;
    end else begin
      state           <= stateNext;
      timer           <= timerNext;
      passwordEntered <= pwNext;
      passwordValid   <= validNext;
      passwordTimeout <= timeoutNext;
      entPrev         <= sensorEntrance;
    end
  end

  // Key capture outranks timeout in ARMED; the car leaving outranks a retry in HOLD.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (entrancePulse) stateNext = ARMED;
      ARMED: begin
        if (keyPulse)                 stateNext = HOLD;
        else if (timer == TIMER_LAST) stateNext = IDLE;
      end
      HOLD:    if (entranceFall) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Timer sits at zero in IDLE so every entry into ARMED starts from a cleared count.
  always_comb begin
    timerNext   = timer;
    pwNext      = passwordEntered;
    validNext   = 1'b0;
    timeoutNext = 1'b0;
    unique case (state)
      IDLE: begin
        timerNext = '0;
        pwNext    = '0;
      end
      ARMED: begin
        if (timer != '1) timerNext = timer + TIMER_W'(1);
        if (keyPulse) begin
          pwNext    = keyCode;
          validNext = 1'b1;
        end else if (timer == TIMER_LAST) begin
          pwNext      = '0;
          timeoutNext = 1'b1;
        end
      end
      HOLD: begin
        if (entranceFall) begin
          pwNext = '0;
        end else if (keyPulse) begin
          pwNext    = keyCode;
          validNext = 1'b1;
        end
      end
      default: begin
        timerNext = '0;
        pwNext    = '0;
      end
    endcase
  end

endmodule
